// File: rtl/alarm_pkg.sv
`timescale 1ns/1ps
// alarm_pkg
//   Shared constants for the alarm ring controller: FSM state encodings,
//   BCD digit width, default ring/snooze durations and a counter-width helper.
package alarm_pkg;

    localparam int BCD_W = 4;

    localparam logic [1:0] DISARMED = 2'd0;
    localparam logic [1:0] ARMED    = 2'd1;
    localparam logic [1:0] RINGING  = 2'd2;
    localparam logic [1:0] SNOOZE   = 2'd3;

    localparam int RING_SECS_DEF   = 60;
    localparam int SNOOZE_SECS_DEF = 300;

    // Width able to hold max_v, with one spare bit of headroom.
    function automatic int ctr_w(input int max_v);
        return $clog2(max_v) + 1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
`timescale 1ns/1ps
// sync_edge_det
//   Two-flop synchroniser for an asynchronous input, followed by an edge
//   register. Produces a registered one-cycle pulse on each rising edge
//   (three clocks after the input rises) and the synchronised level.
// Ports:
//   clk_100MHz  system clock
//   reset       asynchronous, active-high
//   async_i     raw asynchronous input
//   pulse_o     one-cycle rising-edge pulse
//   level_o     synchronised level
module sync_edge_det (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic async_i,
    output logic pulse_o,
    output logic level_o
);

    logic meta_q, sync_q, prev_q, pulse_q;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            meta_q  <= async_i;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            pulse_q <= sync_q & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;
    assign level_o = sync_q;

endmodule

// File: rtl/alarm_ring_ctrl.sv
`timescale 1ns/1ps
// alarm_ring_ctrl
//   Watches the BCD time against the BCD alarm time, rings a gated tone on the
//   buzzer when they match at the top of the minute, and handles stop,
//   snooze and auto-stop. Snooze support is built only when the macro
//   ALARM_SNOOZE_EN is defined; otherwise btn_snooze is ignored, snoozing is
//   held low and the FSM uses only DISARMED/ARMED/RINGING.
// Ports:
//   clk_100MHz, reset             clock, async active-high reset
//   tick_1Hz                      async 1 Hz square wave (second strobe + tone gate)
//   alarm_en, set_alarm           arm switch; edit mode suppresses matching
//   btn_stop, btn_snooze          raw buttons
//   sec_*, min_*, hr_*            current time, BCD
//   alarm_min_*, alarm_hr_*       alarm time, BCD
//   buzzer                        registered gated tone
//   ringing, snoozing, armed      state decodes
module alarm_ring_ctrl
    import alarm_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int TONE_HZ     = 2000,
    parameter int RING_SECS   = RING_SECS_DEF,
    parameter int SNOOZE_SECS = SNOOZE_SECS_DEF,
    parameter int MAX_SNOOZES = 3
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             tick_1Hz,
    input  logic             alarm_en,
    input  logic             set_alarm,
    input  logic             btn_stop,
    input  logic             btn_snooze,
    input  logic [BCD_W-1:0] sec_1s,
    input  logic [BCD_W-1:0] sec_10s,
    input  logic [BCD_W-1:0] min_1s,
    input  logic [BCD_W-1:0] min_10s,
    input  logic [BCD_W-1:0] hr_1s,
    input  logic [BCD_W-1:0] hr_10s,
    input  logic [BCD_W-1:0] alarm_min_1s,
    input  logic [BCD_W-1:0] alarm_min_10s,
    input  logic [BCD_W-1:0] alarm_hr_1s,
    input  logic [BCD_W-1:0] alarm_hr_10s,
    output logic             buzzer,
    output logic             ringing,
    output logic             snoozing,
    output logic             armed
);

    localparam int HALF = CLK_HZ / (2 * TONE_HZ);
    localparam int TW   = ctr_w(HALF);
    localparam int RW   = ctr_w(RING_SECS);
    localparam logic [TW-1:0] TONE_LAST = TW'(HALF - 1);
    localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);

    logic sec_pulse, gate, stop_p, unused_stop_lvl;

    sync_edge_det u_tick (.clk_100MHz(clk_100MHz), .reset(reset), .async_i(tick_1Hz),
                          .pulse_o(sec_pulse), .level_o(gate));
    sync_edge_det u_stop (.clk_100MHz(clk_100MHz), .reset(reset), .async_i(btn_stop),
                          .pulse_o(stop_p), .level_o(unused_stop_lvl));

`ifdef ALARM_SNOOZE_EN
    localparam int SW = ctr_w(SNOOZE_SECS);
    localparam int NW = ctr_w(MAX_SNOOZES);
    localparam logic [SW-1:0] SNZ_LAST = SW'(SNOOZE_SECS - 1);
    localparam logic [NW-1:0] SNZ_MAX  = NW'(MAX_SNOOZES);

    logic          snooze_p, unused_snz_lvl;
    logic [SW-1:0] snz_ctr_q, snz_ctr_d;
    logic [NW-1:0] snz_cnt_q, snz_cnt_d;

    sync_edge_det u_snz (.clk_100MHz(clk_100MHz), .reset(reset), .async_i(btn_snooze),
                         .pulse_o(snooze_p), .level_o(unused_snz_lvl));
`else
    // Snooze path not built: keep its inputs and constants referenced.
    logic [31:0] unused_snz;
    assign unused_snz = {31'd0, btn_snooze} ^ 32'(SNOOZE_SECS) ^ 32'(MAX_SNOOZES) ^ 32'(SNOOZE);
`endif

    logic [1:0]    state_q, state_d;
    logic [RW-1:0] ring_ctr_q, ring_ctr_d;
    logic [TW-1:0] tone_ctr_q, tone_ctr_d;
    logic          tone_q, tone_d;
    logic          buzzer_q, buzzer_d;
    logic          match;

    // Seconds digits must be 00, so a match can only occur once per minute.
    assign match = sec_pulse & ~set_alarm
                 & (hr_10s  == alarm_hr_10s)  & (hr_1s  == alarm_hr_1s)
                 & (min_10s == alarm_min_10s) & (min_1s == alarm_min_1s)
                 & (sec_10s == '0) & (sec_1s == '0);

    always_comb begin
        state_d    = state_q;
        ring_ctr_d = ring_ctr_q;
`ifdef ALARM_SNOOZE_EN
        snz_ctr_d  = snz_ctr_q;
        snz_cnt_d  = snz_cnt_q;
`endif
        if (!alarm_en) begin
            state_d    = DISARMED;
            ring_ctr_d = '0;
`ifdef ALARM_SNOOZE_EN
            snz_ctr_d  = '0;
            snz_cnt_d  = '0;
`endif
        end else begin
            case (state_q)
                DISARMED: state_d = ARMED;
                ARMED: begin
                    if (match) begin
                        state_d    = RINGING;
                        ring_ctr_d = '0;
`ifdef ALARM_SNOOZE_EN
                        snz_cnt_d  = '0;
`endif
                    end
                end
                RINGING: begin
                    // Stop has priority over a simultaneous snooze.
                    if (stop_p) begin
                        state_d = ARMED;
`ifdef ALARM_SNOOZE_EN
                    end else if (snooze_p && (snz_cnt_q < SNZ_MAX)) begin
                        state_d   = SNOOZE;
                        snz_cnt_d = snz_cnt_q + 1'b1;
                        snz_ctr_d = '0;
`endif
                    end else if (sec_pulse) begin
                        if (ring_ctr_q == RING_LAST) state_d = ARMED;
                        else ring_ctr_d = ring_ctr_q + 1'b1;
                    end
                end
`ifdef ALARM_SNOOZE_EN
                SNOOZE: begin
                    if (stop_p) begin
                        state_d = ARMED;
                    end else if (sec_pulse) begin
                        if (snz_ctr_q == SNZ_LAST) begin
                            state_d    = RINGING;
                            ring_ctr_d = '0;
                        end else begin
                            snz_ctr_d = snz_ctr_q + 1'b1;
                        end
                    end
                end
`endif
                default: state_d = DISARMED;
            endcase
        end
    end

    // Tone divider runs only while ringing; parked at zero otherwise.
    always_comb begin
        tone_ctr_d = '0;
        tone_d     = 1'b0;
        if (state_q == RINGING) begin
            if (tone_ctr_q == TONE_LAST) begin
                tone_ctr_d = '0;
                tone_d     = ~tone_q;
            end else begin
                tone_ctr_d = tone_ctr_q + 1'b1;
                tone_d     = tone_q;
            end
        end
    end

    // Using next state drops the buzzer on the same edge that leaves RINGING.
    assign buzzer_d = (state_d == RINGING) & tone_d & gate;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q    <= DISARMED;
            ring_ctr_q <= '0;
            tone_ctr_q <= '0;
            tone_q     <= 1'b0;
            buzzer_q   <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snz_ctr_q  <= '0;
            snz_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ring_ctr_q <= ring_ctr_d;
            tone_ctr_q <= tone_ctr_d;
            tone_q     <= tone_d;
            buzzer_q   <= buzzer_d;
`ifdef ALARM_SNOOZE_EN
            snz_ctr_q  <= snz_ctr_d;
            snz_cnt_q  <= snz_cnt_d;
`endif
        end
    end

    assign buzzer  = buzzer_q;
    assign ringing = (state_q == RINGING);
    assign armed   = (state_q != DISARMED);
`ifdef ALARM_SNOOZE_EN
    assign snoozing = (state_q == SNOOZE);
`else
    assign snoozing = 1'b0;
`endif

endmodule
